// File: rtl/sccb_config_sequencer.sv
// sccb_config_sequencer
// Walks a synchronous config ROM of {reg_addr, value} entries after a start
// pulse and issues one OV7670-style 3-phase SCCB write per entry. Two entry
// codes are reserved: 16'hFFFF ends the table and 16'hFFF0 inserts a fixed
// settle delay (used after a COM7 soft reset). When the table ends, done rises
// and stays high until the next start, which gates the pixel capture path.
//
// Bus timing is built from quarter-bit ticks. A write is START (2 quarters),
// 27 bits of 4 quarters, STOP (3 quarters) and an idle GAP (4 quarters).
// sio_d is only ever driven low or high, or released to the pull-up.

module sccb_config_sequencer #(
  parameter int         QTR_CYCLES   = 62,
  parameter int         DELAY_CYCLES = 250000,
  parameter int         INDEX_WIDTH  = 8,
  parameter logic [7:0] DEVICE_ID    = 8'h42
) (
  input  logic                   clk_25,
  input  logic                   reset,
  input  logic                   start,
  output logic [INDEX_WIDTH-1:0] rom_index,
  input  logic [15:0]            rom_entry,
  output logic                   sio_c,
  inout  wire                    sio_d,
  output logic                   busy,
  output logic                   done
);

  // Sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_BIT   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;
  localparam logic [2:0] ST_DELAY = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  // Reserved table codes
  localparam logic [15:0] ENTRY_TERM  = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

  // Counter widths; both counters need at least one bit
  localparam int QTR_W = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
  localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  localparam logic [QTR_W-1:0] QTR_LAST = QTR_W'(QTR_CYCLES - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);

  // Frame layout is {ID, X, addr, X, value, X}, sent MSB first from bit 26.
  // The X slots are where the slave would answer; the bus is released there.
  localparam logic [26:0] DC_MASK  = {9'b000000001, 9'b000000001, 9'b000000001};
  localparam logic [4:0]  BIT_LAST = 5'd26;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [QTR_W-1:0] qtr_cnt;
  logic [1:0]       qtr;
  logic [4:0]       bit_idx;
  logic [26:0]      frame;
  logic [26:0]      dc_mask;
  logic [DLY_W-1:0] dly_cnt;
  logic             fetch_first;
  logic             sio_d_oe;
  logic             sio_d_out;

  logic             in_frame;
  logic             tick;
  logic             qtr_last;
  logic             phase_end;
  logic             bit_last;
  logic             dly_end;
  logic             entry_end;
  logic             last_index;
  logic             start_accept;
  logic             entry_is_term;
  logic             entry_is_delay;

  assign sio_d = sio_d_oe ? sio_d_out : 1'bz;

  assign in_frame       = (state == ST_START) || (state == ST_BIT) ||
                          (state == ST_STOP)  || (state == ST_GAP);
  assign tick           = in_frame && (qtr_cnt == QTR_LAST);
  assign phase_end      = tick && qtr_last;
  assign bit_last       = (bit_idx == BIT_LAST);
  assign dly_end        = (state == ST_DELAY) && (dly_cnt == DLY_LAST);
  assign entry_end      = ((state == ST_GAP) && phase_end) || dly_end;
  assign last_index     = (rom_index == {INDEX_WIDTH{1'b1}});
  assign start_accept   = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign entry_is_term  = (rom_entry == ENTRY_TERM);
  assign entry_is_delay = (rom_entry == ENTRY_DELAY);

  // Final quarter of each timed phase, so phase_end marks the phase boundary
  always_comb begin
    qtr_last = 1'b0;
    case (state)
      ST_START:        qtr_last = (qtr == 2'd1);
      ST_BIT, ST_GAP:  qtr_last = (qtr == 2'd3);
      ST_STOP:         qtr_last = (qtr == 2'd2);
      default:         qtr_last = 1'b0;
    endcase
  end

  // Next-state decode; start is only honoured from IDLE or DONE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (!fetch_first) begin
          if (entry_is_term)       state_next = ST_DONE;
          else if (entry_is_delay) state_next = ST_DELAY;
          else                     state_next = ST_START;
        end
      end
      ST_START: begin
        if (phase_end) state_next = ST_BIT;
      end
      ST_BIT: begin
        if (phase_end && bit_last) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (phase_end) state_next = ST_GAP;
      end
      ST_GAP, ST_DELAY: begin
        if (entry_end) state_next = last_index ? ST_DONE : ST_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_25) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Marks the first FETCH cycle, while the ROM is still reading the new index
  always_ff @(posedge clk_25) begin
    if (reset) fetch_first <= 1'b0;
    else       fetch_first <= (state_next == ST_FETCH) && (state != ST_FETCH);
  end

  // Quarter-bit prescaler; idle outside a frame so every write starts aligned
  always_ff @(posedge clk_25) begin
    if (reset || !in_frame) qtr_cnt <= '0;
    else if (tick)          qtr_cnt <= '0;
    else                    qtr_cnt <= qtr_cnt + QTR_W'(1);
  end

  // Quarter position inside the current phase
  always_ff @(posedge clk_25) begin
    if (reset || !in_frame) qtr <= 2'd0;
    else if (phase_end)     qtr <= 2'd0;
    else if (tick)          qtr <= qtr + 2'd1;
  end

  // Bit position inside the 27-bit frame
  always_ff @(posedge clk_25) begin
    if (reset || (state != ST_BIT)) bit_idx <= 5'd0;
    else if (phase_end)             bit_idx <= bit_idx + 5'd1;
  end

  // Frame and don't-care shift registers; bit 26 is always the bit on the wire
  always_ff @(posedge clk_25) begin
    if (reset) begin
      frame   <= '0;
      dc_mask <= '0;
    end else if ((state == ST_FETCH) && (state_next == ST_START)) begin
      frame   <= {DEVICE_ID, 1'b0, rom_entry[15:8], 1'b0, rom_entry[7:0], 1'b0};
      dc_mask <= DC_MASK;
    end else if ((state == ST_BIT) && phase_end) begin
      frame   <= {frame[25:0], 1'b0};
      dc_mask <= {dc_mask[25:0], 1'b0};
    end
  end

  // Settle-delay counter, free only while in DELAY
  always_ff @(posedge clk_25) begin
    if (reset || (state != ST_DELAY)) dly_cnt <= '0;
    else                              dly_cnt <= dly_cnt + DLY_W'(1);
  end

  // ROM address: restart at 0 on start, advance per finished entry, never wrap
  always_ff @(posedge clk_25) begin
    if (reset)                         rom_index <= '0;
    else if (start_accept)             rom_index <= '0;
    else if (entry_end && !last_index) rom_index <= rom_index + INDEX_WIDTH'(1);
  end

  // Run status seen by the capture path
  always_ff @(posedge clk_25) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start_accept) begin
      busy <= 1'b1;
      done <= 1'b0;
    end else if ((state_next == ST_DONE) && (state != ST_DONE)) begin
      busy <= 1'b0;
      done <= 1'b1;
    end
  end

  // Bus drivers: each assignment sets the level for the quarter being entered
  always_ff @(posedge clk_25) begin
    if (reset) begin
      sio_c     <= 1'b1;
      sio_d_oe  <= 1'b0;
      sio_d_out <= 1'b1;
    end else begin
      case (state)
        ST_FETCH: begin
          if (state_next == ST_START) begin
            sio_c     <= 1'b1;
            sio_d_oe  <= 1'b1;
            sio_d_out <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (qtr_last) begin
              sio_c     <= 1'b0;
              sio_d_oe  <= ~dc_mask[26];
              sio_d_out <= frame[26];
            end else begin
              sio_d_out <= 1'b0;
            end
          end
        end
        ST_BIT: begin
          if (tick) begin
            if (qtr == 2'd1) begin
              sio_c <= 1'b1;
            end else if (qtr == 2'd3) begin
              sio_c <= 1'b0;
              if (bit_last) begin
                sio_d_oe  <= 1'b1;
                sio_d_out <= 1'b0;
              end else begin
                sio_d_oe  <= ~dc_mask[25];
                sio_d_out <= frame[25];
              end
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (qtr == 2'd0)      sio_c    <= 1'b1;
            else if (qtr == 2'd1) sio_d_oe <= 1'b0;
          end
        end
        default: begin
          sio_c    <= 1'b1;
          sio_d_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// tb_sccb_config_sequencer
// Directed bench for the SCCB config sequencer with a small quarter period and
// delay. Each table write pushes the sio_d levels expected at every sio_c rise
// into a queue; a negedge monitor pops and compares them as the bus toggles.
// Levels are coded 0, 1, or 2 for a released (high-Z) line.

`timescale 1ns/1ps

module tb_sccb_config_sequencer;

  localparam int QTR = 2;
  localparam int DLY = 20;
  localparam int IW  = 4;

  logic          clk_25 = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] rom_index;
  logic [15:0]   rom_entry;
  logic          sio_c;
  logic          busy;
  logic          done;
  wire           sio_d;
  wire           sio_d_released = (sio_d === 1'bz);

  logic [15:0]   rom [0:15];

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int idx_log[$];
  bit sb_enable = 1'b0;
  int start_cnt, stop_cnt, low_pulses, idle_run, max_idle;
  int exp_last_idx;
  int mon_code;
  int prev_code = 2;
  logic prev_c = 1'b1;
  logic prev_busy = 1'b0;
  logic [IW-1:0] prev_idx = '0;

  sccb_config_sequencer #(
    .QTR_CYCLES  (QTR),
    .DELAY_CYCLES(DLY),
    .INDEX_WIDTH (IW),
    .DEVICE_ID   (8'h42)
  ) dut (
    .clk_25   (clk_25),
    .reset    (reset),
    .start    (start),
    .rom_index(rom_index),
    .rom_entry(rom_entry),
    .sio_c    (sio_c),
    .sio_d    (sio_d),
    .busy     (busy),
    .done     (done)
  );

  // 25 MHz clock
  always #20 clk_25 = ~clk_25;

  // Synchronous config ROM: data follows the index by one clock
  always @(posedge clk_25) rom_entry <= rom[rom_index];

  // Counts one comparison and reports it when it does not hold
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(int'(b[i]));
  endtask

  // One write: ID, addr, value each followed by a released don't-care bit,
  // then the stop condition's own sio_c rise with sio_d still held low
  task automatic pushFrame(input logic [15:0] entry);
    pushByte(8'h42);
    exp_q.push_back(2);
    pushByte(entry[15:8]);
    exp_q.push_back(2);
    pushByte(entry[7:0]);
    exp_q.push_back(2);
    exp_q.push_back(0);
  endtask

  // Loads the scoreboard from the table, clears bus statistics, pulses start
  task automatic applyStimulus(input bit score);
    exp_q.delete();
    idx_log.delete();
    start_cnt  = 0;
    stop_cnt   = 0;
    low_pulses = 0;
    max_idle   = 0;
    sb_enable  = score;
    exp_last_idx = 0;
    for (int i = 0; i < 16; i++) begin
      exp_last_idx = i;
      if (rom[i] == 16'hFFFF) break;
      if (score && (rom[i] != 16'hFFF0)) pushFrame(rom[i]);
    end
    start = 1'b1;
    @(negedge clk_25);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    while (!done && (cycles < budget)) begin
      @(negedge clk_25);
      cycles++;
    end
  endtask

  task automatic checkIndexLog(input string tag);
    checkOutput({tag, "_index_count"}, idx_log.size(), exp_last_idx + 1);
    for (int k = 0; k < idx_log.size() && k <= exp_last_idx; k++)
      checkOutput({tag, "_index_seq"}, idx_log[k], k);
  endtask

  // Bus monitor: scoreboard on sio_c rises, start/stop detection, idle runs
  always @(negedge clk_25) begin
    mon_code = sio_d_released ? 2 : ((sio_d === 1'b1) ? 1 : 0);
    if (reset === 1'b0) begin
      if ((sio_c === 1'b1) && (prev_c === 1'b0) && sb_enable) begin
        if (exp_q.size() == 0) checkOutput("sio_d_unexpected_rise", mon_code, -1);
        else                   checkOutput("sio_d_at_sio_c_rise", mon_code, exp_q.pop_front());
      end
      if ((sio_c === 1'b0) && (prev_c === 1'b1)) low_pulses++;
      if ((sio_c === 1'b1) && (prev_c === 1'b1) && (prev_code == 1) && (mon_code == 0)) start_cnt++;
      if ((sio_c === 1'b1) && (prev_c === 1'b1) && (prev_code == 0) && (mon_code == 2)) stop_cnt++;
      if ((busy === 1'b1) && (sio_c === 1'b1) && (mon_code == 2)) begin
        idle_run++;
        if (idle_run > max_idle) max_idle = idle_run;
      end else begin
        idle_run = 0;
      end
      if ((busy === 1'b1) && ((prev_busy !== 1'b1) || (rom_index != prev_idx)))
        idx_log.push_back(int'(rom_index));
    end
    prev_c    = sio_c;
    prev_code = mon_code;
    prev_busy = busy;
    prev_idx  = rom_index;
  end

  initial begin
    int cyc;
    int n;
    bit seen_low;

    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk_25);
    checkOutput("reset_sio_c", int'(sio_c), 1);
    checkOutput("reset_sio_d_released", int'(sio_d_released), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_rom_index", int'(rom_index), 0);
    reset = 1'b0;
    @(negedge clk_25);

    // Single write then terminator
    $display("[TB] single write {1280, FFFF}");
    rom[0] = 16'h1280;
    rom[1] = 16'hFFFF;
    applyStimulus(1'b1);
    checkOutput("single_busy_after_start", int'(busy), 1);
    waitDone(1000, cyc);
    checkOutput("single_done", int'(done), 1);
    checkOutput("single_busy_cleared", int'(busy), 0);
    checkOutput("single_frame_drained", exp_q.size(), 0);
    checkOutput("single_start_conditions", start_cnt, 1);
    checkOutput("single_stop_conditions", stop_cnt, 1);
    checkIndexLog("single");
    repeat (5) @(negedge clk_25);
    checkOutput("single_done_held", int'(done), 1);
    checkOutput("single_idle_sio_d_released", int'(sio_d_released), 1);

    // Two writes around a delay entry
    $display("[TB] delayed table {1280, FFF0, 1100, FFFF}");
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1100;
    rom[3] = 16'hFFFF;
    applyStimulus(1'b1);
    waitDone(2000, cyc);
    checkOutput("delay_done", int'(done), 1);
    checkOutput("delay_frames_drained", exp_q.size(), 0);
    checkOutput("delay_start_conditions", start_cnt, 2);
    checkOutput("delay_stop_conditions", stop_cnt, 2);
    checkOutput("delay_idle_at_least_22", int'(max_idle >= 22), 1);
    // STOP q2 (2) + GAP (8) + FETCH (2) + DELAY (20) + FETCH (2) released cycles
    checkOutput("delay_idle_span", max_idle, 34);
    checkIndexLog("delay");

    // Empty table
    $display("[TB] empty table {FFFF}");
    rom[0] = 16'hFFFF;
    applyStimulus(1'b1);
    checkOutput("empty_busy_after_start", int'(busy), 1);
    waitDone(20, cyc);
    checkOutput("empty_start_to_done_cycles", cyc + 1, 3);
    checkOutput("empty_done", int'(done), 1);
    checkOutput("empty_no_sio_c_low", low_pulses, 0);

    // Second start mid-write must be ignored
    $display("[TB] start pulsed during a write");
    rom[0] = 16'h1280;
    rom[1] = 16'hFFFF;
    applyStimulus(1'b1);
    repeat (40) @(negedge clk_25);
    start = 1'b1;
    @(negedge clk_25);
    start = 1'b0;
    waitDone(1000, cyc);
    checkOutput("midstart_done", int'(done), 1);
    checkOutput("midstart_frame_drained", exp_q.size(), 0);
    checkOutput("midstart_start_conditions", start_cnt, 1);
    checkIndexLog("midstart");
    applyStimulus(1'b1);
    waitDone(1000, cyc);
    checkOutput("rerun_done", int'(done), 1);
    checkOutput("rerun_frame_drained", exp_q.size(), 0);
    checkIndexLog("rerun");

    // Reset during BIT q2 of the first bit
    $display("[TB] reset during a write");
    applyStimulus(1'b0);
    n = 0;
    seen_low = 1'b0;
    while (n < 400) begin
      @(negedge clk_25);
      n++;
      if (sio_c === 1'b0) seen_low = 1'b1;
      else if (seen_low) break;
    end
    checkOutput("abort_reached_bit_q2", int'(seen_low && (sio_c === 1'b1)), 1);
    reset = 1'b1;
    @(negedge clk_25);
    checkOutput("abort_sio_c", int'(sio_c), 1);
    checkOutput("abort_sio_d_released", int'(sio_d_released), 1);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_rom_index", int'(rom_index), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk_25);
    checkOutput("abort_no_restart_busy", int'(busy), 0);
    checkOutput("abort_no_restart_sio_c", int'(sio_c), 1);
    applyStimulus(1'b1);
    waitDone(1000, cyc);
    checkOutput("abort_clean_done", int'(done), 1);
    checkOutput("abort_clean_frame_drained", exp_q.size(), 0);
    checkOutput("abort_clean_start_conditions", start_cnt, 1);
    checkOutput("abort_clean_stop_conditions", stop_cnt, 1);

    // Full table without terminator: stops at the last index
    $display("[TB] 16 writes, no terminator");
    for (int i = 0; i < 16; i++) rom[i] = 16'(16'h2000 + i * 16'h0103);
    applyStimulus(1'b1);
    waitDone(8000, cyc);
    checkOutput("full_done", int'(done), 1);
    checkOutput("full_frames_drained", exp_q.size(), 0);
    checkOutput("full_start_conditions", start_cnt, 16);
    checkOutput("full_stop_conditions", stop_cnt, 16);
    checkOutput("full_final_rom_index", int'(rom_index), 15);
    checkIndexLog("full");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
